// File: rtl/l2_wbuf_pkg.sv
// l2_wbuf_pkg: shared types for the L2 victim write buffer (read forwarding gated by L2_WBUF_FWD_EN)
package l2_wbuf_pkg;
  localparam int L2_ADDR_W = 32;
  localparam int L2_LINE_W = 256;
  localparam int L2_OFFSET_W = 5;
  localparam int L2_LA_W = L2_ADDR_W - L2_OFFSET_W;
  typedef enum logic [1:0] {IDLE, ACK, DRAIN, FETCH} l2_wbuf_state_t;
  typedef struct packed {
    logic [L2_LA_W-1:0]   line_addr;
    logic [L2_LINE_W-1:0] data;
  } l2_wbuf_entry_t;
  function automatic logic [L2_LA_W-1:0] line_addr(input logic [L2_ADDR_W-1:0] addr);
    return addr[L2_ADDR_W-1:L2_OFFSET_W];
  endfunction
endpackage

// File: rtl/l2_wbuf_fifo.sv
// l2_wbuf_fifo: circular line store with parallel line-address match and in-place merge
module l2_wbuf_fifo
  import l2_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 merge,
  input  logic                 pop,
  input  logic [L2_LA_W-1:0]   lookup_line,
  input  logic [L2_LINE_W-1:0] wr_data,
  output logic                 hit,
  output logic [L2_LINE_W-1:0] hit_data,
  output l2_wbuf_entry_t       head,
  output logic                 full,
  output logic                 empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  l2_wbuf_entry_t mem_q [DEPTH];
  l2_wbuf_entry_t mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, hit_idx;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign valid[g] = ((g + DEPTH - int'(head_q)) % DEPTH) < int'(count_q);
  end
  // Writes merge, so at most one valid slot can match a line.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && mem_q[i].line_addr == lookup_line) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
  end
  assign hit_data = mem_q[hit_idx].data;
  assign head = mem_q[head_q];
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  always_comb begin
    mem_d = mem_q;
    if (merge) mem_d[hit_idx].data = wr_data;
    else if (push) mem_d[tail_q] = '{line_addr: lookup_line, data: wr_data};
    head_d = pop ? nxt(head_q) : head_q;
    tail_d = push ? nxt(tail_q) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: L2 victim write buffer FSM; define L2_WBUF_FWD_EN to forward buffered lines to reads
module l2_writeback_buffer
  import l2_wbuf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = L2_ADDR_W,
  parameter int LINE_W   = L2_LINE_W,
  parameter int OFFSET_W = L2_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_address,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              l2_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  l2_wbuf_state_t state_q, state_d;
  logic [LINE_W-1:0] rdata_q, rdata_d, load_data;
  logic push, merge, pop, load, hit, full, empty;
  logic [LINE_W-1:0] hit_data;
  l2_wbuf_entry_t head;
  l2_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .merge       (merge),
    .pop         (pop),
    .lookup_line (line_addr(l2_address)),
    .wr_data     (l2_wdata),
    .hit         (hit),
    .hit_data    (hit_data),
    .head        (head),
    .full        (full),
    .empty       (empty)
  );
  assign load_data = (state_q == FETCH) ? pmem_rdata : hit_data;
  always_comb begin
    state_d = state_q;
    push = 1'b0;
    merge = 1'b0;
    pop = 1'b0;
    load = 1'b0;
    case (state_q)
      IDLE:
        if (l2_write) begin
          merge = hit;
          push = !hit && !full;
          state_d = (hit || !full) ? ACK : DRAIN;
        end else if (l2_read) begin
`ifdef L2_WBUF_FWD_EN
          load = hit;
          state_d = hit ? ACK : FETCH;
`else
          state_d = hit ? DRAIN : FETCH;
`endif
        end else if (!empty) state_d = DRAIN;
      ACK: state_d = IDLE;
      DRAIN: begin
        pop = pmem_resp;
        state_d = pmem_resp ? IDLE : DRAIN;
      end
      FETCH: begin
        load = pmem_resp;
        state_d = pmem_resp ? ACK : FETCH;
      end
      default: state_d = IDLE;
    endcase
    rdata_d = load ? load_data : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end
  assign l2_rdata = rdata_q;
  assign l2_resp = state_q == ACK;
  assign pmem_write = state_q == DRAIN;
  assign pmem_read = state_q == FETCH;
  assign pmem_address = pmem_write ? {head.line_addr, {OFFSET_W{1'b0}}} : pmem_read ? l2_address : '0;
  assign pmem_wdata = pmem_write ? head.data : '0;
  assert property (@(posedge clk) disable iff (rst) !(l2_read && l2_write));
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: directed and random L2/memory traffic against a line-level buffer model
module tb_l2_writeback_buffer;
  localparam int LA_W = 27;
  logic clk = 1'b0, rst = 1'b1, l2_read = 1'b0, l2_write = 1'b0, pmem_resp = 1'b0;
  logic [31:0] l2_address = '0;
  logic [255:0] l2_wdata = '0, pmem_rdata = '0;
  logic [255:0] l2_rdata, pmem_wdata;
  logic l2_resp, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  always #5 clk = ~clk;
  l2_writeback_buffer dut (
    .clk(clk), .rst(rst), .l2_read(l2_read), .l2_write(l2_write),
    .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  typedef struct {
    logic [LA_W-1:0] la;
    logic [255:0]    d;
  } ent_t;
  ent_t q_m[$];
  logic [255:0] mem_m [logic [LA_W-1:0]];
  int total = 0, bad = 0, wr_cnt = 0, rd_cnt = 0, mem_lat = 2, age = 0;
  bit hold = 1'b0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
  bit op_wr;
  logic [31:0] op_addr;
  logic [255:0] op_data;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] mem_val(input logic [LA_W-1:0] la);
    if (mem_m.exists(la)) return mem_m[la];
    return {8{5'h0, la}} ^ {8{32'h5a5a0000}};
  endfunction
  function automatic logic [255:0] golden(input logic [LA_W-1:0] la);
    foreach (q_m[i]) if (q_m[i].la == la) return q_m[i].d;
    return mem_val(la);
  endfunction
  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  // Memory: answers after mem_lat cycles; drained lines must come out in FIFO order.
  initial forever begin
    @(negedge clk);
    pmem_resp = 1'b0;
    if (rst || hold || !(pmem_write || pmem_read)) age = 0;
    else begin
      age++;
      if (age >= mem_lat) begin
        age = 0;
        pmem_resp = 1'b1;
        if (pmem_write) begin
          wr_cnt++;
          last_wr_addr = pmem_address;
          chk("wr_offset", 256'(pmem_address[4:0]), 256'(0));
          chk("wr_pending", 256'(q_m.size() > 0), 256'(1));
          if (q_m.size() > 0) begin
            chk("wr_addr", 256'(pmem_address[31:5]), 256'(q_m[0].la));
            chk("wr_data", pmem_wdata, q_m[0].d);
            mem_m[q_m[0].la] = pmem_wdata;
            void'(q_m.pop_front());
          end
        end else begin
          rd_cnt++;
          last_rd_addr = pmem_address;
          pmem_rdata = mem_val(pmem_address[31:5]);
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic start(input bit wr, input logic [31:0] addr, input logic [255:0] data);
    op_wr = wr;
    op_addr = addr;
    op_data = data;
    l2_write = wr;
    l2_read = !wr;
    l2_address = addr;
    l2_wdata = data;
  endtask
  task automatic finish(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!l2_resp && lat < 400);
    chk("resp_seen", 256'(l2_resp), 256'(1));
    l2_write = 1'b0;
    l2_read = 1'b0;
    if (op_wr) begin
      int k = -1;
      foreach (q_m[i]) if (q_m[i].la == op_addr[31:5]) k = i;
      if (k >= 0) q_m[k].d = op_data;
      else q_m.push_back('{op_addr[31:5], op_data});
      chk("occupancy", 256'(q_m.size() <= 4), 256'(1));
    end else chk("rd_data", l2_rdata, golden(op_addr[31:5]));
  endtask
  task automatic drain_wait();
    int n = 0;
    while ((q_m.size() != 0 || pmem_write) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_done", 256'(q_m.size()), 256'(0));
  endtask
  initial begin
    int lat, w0, r0;
    logic [255:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 256'(l2_resp), 256'(0));
    chk("rst_pread", 256'(pmem_read), 256'(0));
    chk("rst_pwrite", 256'(pmem_write), 256'(0));
    chk("rst_paddr", 256'(pmem_address), 256'(0));
    chk("rst_pwdata", pmem_wdata, 256'(0));
    chk("rst_rdata", l2_rdata, 256'(0));
    rst = 1'b0;
    tick();
    x = rnd();
    w0 = wr_cnt;
    start(1'b1, 32'h1000, x);
    finish(lat);
    chk("t1_lat", 256'(lat inside {[1:2]}), 256'(1));
    chk("t1_no_write", 256'(pmem_write), 256'(0));
    drain_wait();
    chk("t1_drains", 256'(wr_cnt - w0), 256'(1));
    chk("t1_addr", 256'(last_wr_addr), 256'(32'h1000));
    chk("t1_mem", mem_val(27'(32'h1000 >> 5)), x);
    tick(4);
    chk("t1_quiet", 256'(pmem_write), 256'(0));
    hold = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      start(1'b1, 32'h5000 + 32'(i * 32), rnd());
      finish(lat);
    end
    start(1'b1, 32'h5080, rnd());
    tick(4);
    chk("t2_full_drain", 256'(pmem_write), 256'(1));
    chk("t2_head_addr", 256'(pmem_address), 256'(32'h5000));
    chk("t2_no_resp", 256'(l2_resp), 256'(0));
    hold = 1'b0;
    finish(lat);
    chk("t2_one_drain", 256'(wr_cnt - w0), 256'(1));
    drain_wait();
    x = rnd();
    y = rnd();
    hold = 1'b1;
    w0 = wr_cnt;
    start(1'b1, 32'h2000, x);
    finish(lat);
    start(1'b1, 32'h2000, y);
    finish(lat);
    hold = 1'b0;
    drain_wait();
    chk("t3_drains", 256'(wr_cnt - w0), 256'(1));
    chk("t3_mem", mem_val(27'(32'h2000 >> 5)), y);
    x = rnd();
    w0 = wr_cnt;
    r0 = rd_cnt;
    start(1'b1, 32'h3000, x);
    finish(lat);
    start(1'b0, 32'h3000, '0);
    finish(lat);
    chk("t4_data", l2_rdata, x);
`ifdef L2_WBUF_FWD_EN
    chk("t4_no_fetch", 256'(rd_cnt - r0), 256'(0));
    chk("t4_no_drain", 256'(wr_cnt - w0), 256'(0));
`else
    chk("t4_fetch", 256'(rd_cnt - r0), 256'(1));
    chk("t4_drain_first", 256'(wr_cnt - w0), 256'(1));
`endif
    tick(3);
    chk("t4_hold", l2_rdata, x);
    drain_wait();
    mem_lat = 3;
    r0 = rd_cnt;
    start(1'b0, 32'h4000, '0);
    finish(lat);
    chk("t5_addr", 256'(last_rd_addr), 256'(32'h4000));
    chk("t5_data", l2_rdata, mem_val(27'(32'h4000 >> 5)));
    chk("t5_fetch", 256'(rd_cnt - r0), 256'(1));
    chk("t5_lat", 256'(lat inside {[4:5]}), 256'(1));
    mem_lat = 2;
    hold = 1'b1;
    start(1'b1, 32'h6000, rnd());
    finish(lat);
    tick(3);
    chk("t6_draining", 256'(pmem_write), 256'(1));
    rst = 1'b1;
    tick();
    chk("t6_write_drop", 256'(pmem_write), 256'(0));
    chk("t6_resp_drop", 256'(l2_resp), 256'(0));
    rst = 1'b0;
    q_m.delete();
    hold = 1'b0;
    r0 = rd_cnt;
    start(1'b0, 32'h6000, '0);
    finish(lat);
    chk("t6_fetch", 256'(rd_cnt - r0), 256'(1));
    chk("t6_old_data", l2_rdata, mem_val(27'(32'h6000 >> 5)));
    tick(5);
    chk("t6_empty", 256'(pmem_write), 256'(0));
    for (int n = 0; n < 200; n++) begin
      mem_lat = $urandom_range(1, 4);
      start(1'($urandom_range(0, 1)), 32'h8000 + 32'($urandom_range(0, 5) * 32) + 32'($urandom_range(0, 31)), rnd());
      finish(lat);
      tick($urandom_range(0, 3));
    end
    drain_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
